// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU types and Funct3 encodings
//
// Purpose: state encoding for the iterative divider and the M-extension
// Funct3 codes for DIV/DIVU/REM/REMU.
// Ports: none (package).

package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divstate_t;

  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

endpackage

// File: rtl/divstep.sv
// rtl/divstep.sv - one combinational restoring-division iteration
//
// Purpose: shifts {r,q} left by one, trial-subtracts the divisor and
// restores on borrow, producing the next partial remainder and quotient.
// Ports:
//   r      in   XLEN+1  partial remainder
//   q      in   XLEN    dividend / quotient shift register
//   d      in   XLEN    divisor magnitude
//   rnext  out  XLEN+1  partial remainder after this step
//   qnext  out  XLEN    quotient register after this step

module divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   r,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] d,
  output logic [XLEN:0]   rnext,
  output logic [XLEN-1:0] qnext
);

  // One bit wider than the shifted remainder so the top bit of the
  // difference is a clean borrow flag.
  logic [XLEN+1:0] rshift;
  logic [XLEN+1:0] diff;
  logic            borrow;

  assign rshift = {r, q[XLEN-1]};
  assign diff   = rshift - {2'b00, d};
  assign borrow = diff[XLEN+1];

  assign rnext = borrow ? rshift[XLEN:0] : diff[XLEN:0];
  assign qnext = {q[XLEN-2:0], ~borrow};

endmodule

// File: rtl/intdiv_radix2.sv
// rtl/intdiv_radix2.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
//
// Purpose: computes quotient and remainder of XLEN-bit operands, one
// quotient bit per cycle, with sign correction applied on the outputs.
// Ports:
//   clk             in   1     clock
//   reset           in   1     asynchronous active-high reset
//   FlushE          in   1     abort in-flight operation, suppress done
//   DivStartE       in   1     start request, sampled only in IDLE
//   ForwardedSrcAE  in   XLEN  dividend
//   ForwardedSrcBE  in   XLEN  divisor
//   Funct3E         in   3     M-extension funct3 (bit 0 = unsigned)
//   DivBusyE        out  1     state is not IDLE
//   DivDoneE        out  1     one-cycle result-valid pulse
//   QuotE           out  XLEN  corrected quotient
//   RemE            out  XLEN  corrected remainder

module intdiv_radix2
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            DivStartE,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  input  logic [2:0]      Funct3E,
  output logic            DivBusyE,
  output logic            DivDoneE,
  output logic [XLEN-1:0] QuotE,
  output logic [XLEN-1:0] RemE
);

  localparam int CW = $clog2(XLEN);

  divstate_t state, state_n;

  logic [XLEN-1:0] q, d;
  logic [XLEN:0]   r;
  logic [CW-1:0]   cnt;
  logic            negq, negr;

  logic [XLEN:0]   step_r;
  logic [XLEN-1:0] step_q;

  logic            signed_op;
  logic            divzero;
  logic            start;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            unused_funct3;

  // Only the unsigned bit selects behaviour; DIV vs REM differ only in
  // which output the pipeline consumes.
  assign unused_funct3 = ^Funct3E[2:1];

  assign signed_op = ~Funct3E[0];
  assign divzero   = (ForwardedSrcBE == '0);
  assign start     = (state == IDLE) & DivStartE & ~FlushE;

  assign a_neg = signed_op & ForwardedSrcAE[XLEN-1];
  assign b_neg = signed_op & ForwardedSrcBE[XLEN-1];
  // The most-negative value maps onto itself, which is the correct
  // unsigned magnitude 2^(XLEN-1).
  assign a_mag = a_neg ? -ForwardedSrcAE : ForwardedSrcAE;
  assign b_mag = b_neg ? -ForwardedSrcBE : ForwardedSrcBE;

  divstep #(.XLEN(XLEN)) u_step (
    .r     (r),
    .q     (q),
    .d     (d),
    .rnext (step_r),
    .qnext (step_q)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state; flush overrides everything, including a same-cycle start.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) state_n = divzero ? DONE : BUSY;
      end
      BUSY: begin
        if (cnt == '0) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (FlushE) state_n = IDLE;
  end

  // Working registers: loaded on an accepted start, advanced in BUSY,
  // otherwise held so the outputs stay valid until the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      d    <= '0;
      r    <= '0;
      cnt  <= '0;
      negq <= 1'b0;
      negr <= 1'b0;
    end else if (start) begin
      cnt <= CW'(XLEN - 1);
      d   <= b_mag;
      if (divzero) begin
        // Architectural divide-by-zero result: all-ones quotient and the
        // raw dividend as remainder, with no sign correction.
        q    <= '1;
        r    <= {1'b0, ForwardedSrcAE};
        negq <= 1'b0;
        negr <= 1'b0;
      end else begin
        q    <= a_mag;
        r    <= '0;
        negq <= a_neg ^ b_neg;
        negr <= a_neg;
      end
    end else if ((state == BUSY) && !FlushE) begin
      q   <= step_q;
      r   <= step_r;
      cnt <= cnt - CW'(1);
    end
  end

  assign DivBusyE = (state != IDLE);
  assign DivDoneE = (state == DONE) & ~FlushE;
  assign QuotE    = negq ? -q : q;
  assign RemE     = negr ? -r[XLEN-1:0] : r[XLEN-1:0];

endmodule

// File: tb/tb_intdiv_radix2.sv
// tb/tb_intdiv_radix2.sv - self-checking bench for intdiv_radix2

module tb_intdiv_radix2;
  import mdu_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            FlushE;
  logic            DivStartE;
  logic [XLEN-1:0] a, b;
  logic [2:0]      f3;
  logic            DivBusyE, DivDoneE;
  logic [XLEN-1:0] QuotE, RemE;

  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  intdiv_radix2 #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .FlushE         (FlushE),
    .DivStartE      (DivStartE),
    .ForwardedSrcAE (a),
    .ForwardedSrcBE (b),
    .Funct3E        (f3),
    .DivBusyE       (DivBusyE),
    .DivDoneE       (DivDoneE),
    .QuotE          (QuotE),
    .RemE           (RemE)
  );

  function automatic exp_t model(logic [XLEN-1:0] x, logic [XLEN-1:0] y, logic [2:0] fn);
    exp_t e;
    logic signed [XLEN-1:0] sx, sy;
    sx = x;
    sy = y;
    if (y == 0) begin
      e.q = '1;
      e.r = x;
    end else if (fn[0]) begin
      e.q = x / y;
      e.r = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.q = x;
      e.r = '0;
    end else begin
      e.q = sx / sy;
      e.r = sx % sy;
    end
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    #2;
    if (!reset && DivDoneE) begin
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done quot=%h rem=%h required no done", QuotE, RemE);
      end else begin
        e = sbq.pop_front();
        if (QuotE !== e.q || RemE !== e.r) begin
          failures++;
          $display("FAIL result quot=%h rem=%h required quot=%h rem=%h", QuotE, RemE, e.q, e.r);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives a start for one cycle (called at a negedge), returns at the
  // sample point of cycle 1.
  task automatic issue(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       input logic [2:0] fn, input bit push);
    a = x;
    b = y;
    f3 = fn;
    DivStartE = 1'b1;
    if (push) sbq.push_back(model(x, y, fn));
    @(negedge clk);
    DivStartE = 1'b0;
  endtask

  // Records busy/done behaviour over cycles 1..ncyc; stays at cycle ncyc.
  task automatic observe(input int ncyc, output int busy_n, output int last_busy,
                         output int done_n, output int done_at);
    busy_n = 0; last_busy = 0; done_n = 0; done_at = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (DivBusyE) begin busy_n++; last_busy = c; end
      if (DivDoneE) begin done_n++; if (done_at == 0) done_at = c; end
      if (c < ncyc) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; FlushE = 1'b0; DivStartE = 1'b0; a = '0; b = '0; f3 = DIV;
    repeat (2) @(negedge clk);
    checks++;
    if (DivBusyE !== 1'b0 || DivDoneE !== 1'b0 || QuotE !== '0 || RemE !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b quot=%h rem=%h required 0 0 0 0",
               DivBusyE, DivDoneE, QuotE, RemE);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic;
    int bn, lb, dn, da;
    issue(32'd20, 32'd3, DIVU, 1);
    observe(XLEN + 2, bn, lb, dn, da);
    checks++;
    if (bn != XLEN + 1 || lb != XLEN + 1) begin
      failures++;
      $display("FAIL divu_busy cycles=%0d last=%0d required %0d %0d", bn, lb, XLEN + 1, XLEN + 1);
    end
    checks++;
    if (dn != 1 || da != XLEN + 1) begin
      failures++;
      $display("FAIL divu_done count=%0d cycle=%0d required 1 %0d", dn, da, XLEN + 1);
    end
    checks++;
    if (QuotE !== 32'd6 || RemE !== 32'd2) begin
      failures++;
      $display("FAIL divu_hold quot=%h rem=%h required 6 2", QuotE, RemE);
    end
  endtask

  task automatic test_signed;
    int bn, lb, dn, da;
    issue(32'hFFFF_FFF9, 32'd2, DIV, 1);
    observe(XLEN + 2, bn, lb, dn, da);
    checks++;
    if (da != XLEN + 1 || QuotE !== 32'hFFFF_FFFD || RemE !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_neg7_2 done=%0d quot=%h rem=%h required %0d fffffffd ffffffff",
               da, QuotE, RemE, XLEN + 1);
    end
  endtask

  task automatic test_overflow;
    int bn, lb, dn, da;
    issue(32'h8000_0000, 32'hFFFF_FFFF, DIV, 1);
    observe(XLEN + 2, bn, lb, dn, da);
    checks++;
    if (da != XLEN + 1 || QuotE !== 32'h8000_0000 || RemE !== 32'h0) begin
      failures++;
      $display("FAIL div_overflow done=%0d quot=%h rem=%h required %0d 80000000 0",
               da, QuotE, RemE, XLEN + 1);
    end
  endtask

  task automatic test_div_zero;
    int bn, lb, dn, da;
    issue(32'hFFFF_FFFB, 32'd0, REM, 1);
    observe(2, bn, lb, dn, da);
    checks++;
    if (bn != 1 || lb != 1 || dn != 1 || da != 1) begin
      failures++;
      $display("FAIL divzero_timing busy=%0d last=%0d done=%0d at=%0d required 1 1 1 1",
               bn, lb, dn, da);
    end
    checks++;
    if (QuotE !== 32'hFFFF_FFFF || RemE !== 32'hFFFF_FFFB) begin
      failures++;
      $display("FAIL rem_neg5_0 quot=%h rem=%h required ffffffff fffffffb", QuotE, RemE);
    end
    // Back-to-back issue in cycle 2 after a divide by zero.
    issue(32'd5, 32'd0, DIVU, 1);
    observe(2, bn, lb, dn, da);
    checks++;
    if (da != 1 || QuotE !== 32'hFFFF_FFFF || RemE !== 32'd5) begin
      failures++;
      $display("FAIL divu_5_0 done=%0d quot=%h rem=%h required 1 ffffffff 5", da, QuotE, RemE);
    end
  endtask

  task automatic test_flush;
    int bn, lb, dn, da;
    issue(32'd100, 32'd7, DIVU, 0);
    observe(10, bn, lb, dn, da);
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    checks++;
    if (bn != 10 || dn != 0 || DivBusyE !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy busy=%0d done=%0d busy11=%b required 10 0 0", bn, dn, DivBusyE);
    end
    issue(32'd9, 32'd3, DIVU, 1);
    observe(XLEN + 2, bn, lb, dn, da);
    checks++;
    if (dn != 1 || da != XLEN + 1 || QuotE !== 32'd3 || RemE !== 32'd0) begin
      failures++;
      $display("FAIL after_flush done=%0d at=%0d quot=%h rem=%h required 1 %0d 3 0",
               dn, da, QuotE, RemE, XLEN + 1);
    end
    // Flush beats a same-cycle start.
    a = 32'd1; b = 32'd1; f3 = DIVU;
    DivStartE = 1'b1;
    FlushE = 1'b1;
    @(negedge clk);
    DivStartE = 1'b0;
    FlushE = 1'b0;
    checks++;
    if (DivBusyE !== 1'b0) begin
      failures++;
      $display("FAIL flush_wins busy=%b required 0", DivBusyE);
    end
    // Flush during DONE suppresses the pulse.
    issue(32'd5, 32'd0, DIVU, 0);
    FlushE = 1'b1;
    #1;
    checks++;
    if (DivDoneE !== 1'b0 || DivBusyE !== 1'b1) begin
      failures++;
      $display("FAIL flush_in_done done=%b busy=%b required 0 1", DivDoneE, DivBusyE);
    end
    @(negedge clk);
    FlushE = 1'b0;
    checks++;
    if (DivBusyE !== 1'b0) begin
      failures++;
      $display("FAIL flush_done_idle busy=%b required 0", DivBusyE);
    end
  endtask

  task automatic test_hold_start_and_reset;
    int bn = 0, dn = 0, da = 0;
    a = 32'd20; b = 32'd3; f3 = DIVU;
    DivStartE = 1'b1;
    sbq.push_back(model(32'd20, 32'd3, DIVU));
    @(negedge clk);
    for (int c = 1; c <= XLEN + 1; c++) begin
      if (DivBusyE) bn++;
      if (DivDoneE) begin dn++; da = c; end
      a = $urandom;
      b = $urandom;
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      @(negedge clk);
    end
    checks++;
    if (bn != XLEN + 1 || dn != 1 || da != XLEN + 1) begin
      failures++;
      $display("FAIL held_start busy=%0d done=%0d at=%0d required %0d 1 %0d",
               bn, dn, da, XLEN + 1, XLEN + 1);
    end
    checks++;
    if (QuotE !== 32'd6 || RemE !== 32'd2 || DivBusyE !== 1'b0) begin
      failures++;
      $display("FAIL held_result quot=%h rem=%h busy=%b required 6 2 0", QuotE, RemE, DivBusyE);
    end
    a = 32'd1000; b = 32'd10; f3 = DIVU;
    @(negedge clk);
    DivStartE = 1'b0;
    checks++;
    if (DivBusyE !== 1'b1) begin
      failures++;
      $display("FAIL start_cycle34 busy=%b required 1", DivBusyE);
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (DivBusyE !== 1'b0 || DivDoneE !== 1'b0 || QuotE !== '0 || RemE !== '0) begin
      failures++;
      $display("FAIL midop_reset busy=%b done=%b quot=%h rem=%h required 0 0 0 0",
               DivBusyE, DivDoneE, QuotE, RemE);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (XLEN + 4) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int bn, lb, dn, da;
    logic [XLEN-1:0] x, y;
    logic [2:0] fn;
    for (int i = 0; i < 10; i++) begin
      x = $urandom;
      if (i % 3 == 0) x = 32'($urandom_range(0, 200));
      case ($urandom_range(0, 3))
        0: y = '0;
        1: y = 32'($urandom_range(1, 15));
        2: y = -32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      fn = 3'b100 | 3'(i % 4);
      issue(x, y, fn, 1);
      observe((y == 0) ? 2 : XLEN + 2, bn, lb, dn, da);
      checks++;
      if (dn != 1 || da != ((y == 0) ? 1 : XLEN + 1)) begin
        failures++;
        $display("FAIL b2b_timing op=%0d done=%0d at=%0d required 1 %0d",
                 i, dn, da, (y == 0) ? 1 : XLEN + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_divu_basic;
    test_signed;
    test_overflow;
    test_div_zero;
    test_flush;
    test_hold_start_and_reset;
    sbq.delete();
    test_back_to_back;
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
